// File: rtl/fetch_pc_unit.sv
// IF-stage PC sequencer: one outstanding imem request, single-entry instruction buffer,
// EX redirects squash wrong-path requests and buffered instructions.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_redirect_valid,
  input  logic [31:0] io_redirect_pc,
  output logic        io_imem_req_valid,
  input  logic        io_imem_req_ready,
  output logic [31:0] io_imem_req_addr,
  input  logic        io_imem_resp_valid,
  input  logic [31:0] io_imem_resp_data,
  output logic        io_if_valid,
  input  logic        io_if_ready,
  output logic [31:0] io_if_pc,
  output logic [31:0] io_if_inst
);

  // state | meaning
  // SEND  | request fetch_pc | WAIT | awaiting response | HOLD | word offered to decode | DROP | swallow stale response
  typedef enum logic [1:0] {SEND, WAIT, HOLD, DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] inst_q, inst_d;

  logic [31:0] redirect_pc;
  logic        req_fire;
  logic        if_fire;

  assign redirect_pc = io_redirect_pc & ~32'h3;
  assign req_fire    = io_imem_req_valid & io_imem_req_ready;
  assign if_fire     = io_if_valid & io_if_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= SEND;
      fetch_pc_q <= RESET_PC;
      inst_pc_q  <= 32'h0;
      inst_q     <= 32'h0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inst_pc_q  <= inst_pc_d;
      inst_q     <= inst_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    inst_pc_d  = inst_pc_q;
    inst_d     = inst_q;
    unique case (state_q)
      SEND: begin
        if (io_redirect_valid) begin
          fetch_pc_d = redirect_pc;
          if (req_fire) state_d = DROP;
        end else if (req_fire) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (io_redirect_valid) begin
          fetch_pc_d = redirect_pc;
          state_d    = io_imem_resp_valid ? SEND : DROP;
        end else if (io_imem_resp_valid) begin
          inst_d     = io_imem_resp_data;
          inst_pc_d  = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (io_redirect_valid) begin
          fetch_pc_d = redirect_pc;
          state_d    = SEND;
        end else if (if_fire) begin
          state_d = SEND;
        end
      end
      DROP: begin
        if (io_redirect_valid) fetch_pc_d = redirect_pc;
        if (io_imem_resp_valid) state_d = SEND;
      end
      default: state_d = SEND;
    endcase
  end

  // Redirect masks if_valid combinationally so decode never takes a squashed word.
  always_comb begin
    io_imem_req_valid = !reset && (state_q == SEND);
    io_imem_req_addr  = fetch_pc_q & ~32'h3;
    io_if_valid       = !reset && (state_q == HOLD) && !io_redirect_valid;
    io_if_pc          = inst_pc_q;
    io_if_inst        = inst_q;
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed scenarios plus randomized traffic, checked against a transaction-level
// model (pc, outstanding/squashed request, one-entry buffer).
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_redirect_valid;
  logic [31:0] io_redirect_pc;
  logic        io_imem_req_valid;
  logic        io_imem_req_ready;
  logic [31:0] io_imem_req_addr;
  logic        io_imem_resp_valid;
  logic [31:0] io_imem_resp_data;
  logic        io_if_valid;
  logic        io_if_ready;
  logic [31:0] io_if_pc;
  logic [31:0] io_if_inst;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_pc;
  logic        m_out, m_squash, m_buf;
  logic [31:0] m_buf_pc, m_buf_inst;
  logic        mem_pend;

  always #5 clock = ~clock;

  fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
    .clock              (clock),
    .reset              (reset),
    .io_redirect_valid  (io_redirect_valid),
    .io_redirect_pc     (io_redirect_pc),
    .io_imem_req_valid  (io_imem_req_valid),
    .io_imem_req_ready  (io_imem_req_ready),
    .io_imem_req_addr   (io_imem_req_addr),
    .io_imem_resp_valid (io_imem_resp_valid),
    .io_imem_resp_data  (io_imem_resp_data),
    .io_if_valid        (io_if_valid),
    .io_if_ready        (io_if_ready),
    .io_if_pc           (io_if_pc),
    .io_if_inst         (io_if_inst)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic rd, input logic [31:0] rpc, input logic rq_rdy,
                      input logic rsp_v, input logic [31:0] rsp_d, input logic ifr,
                      input logic rst, output logic acc);
    logic e_req, e_if, o_out, o_buf;
    @(negedge clock);
    reset              = rst;
    io_redirect_valid  = rd;
    io_redirect_pc     = rpc;
    io_imem_req_ready  = rq_rdy;
    io_imem_resp_valid = rsp_v;
    io_imem_resp_data  = rsp_d;
    io_if_ready        = ifr;
    #1;
    e_req = !rst && !m_out && !m_buf;
    e_if  = !rst && m_buf && !rd;
    chk("req_valid", {31'b0, io_imem_req_valid}, {31'b0, e_req});
    chk("req_addr_align", {30'b0, io_imem_req_addr[1:0]}, 32'h0);
    if (e_req) chk("req_addr", io_imem_req_addr, m_pc);
    chk("if_valid", {31'b0, io_if_valid}, {31'b0, e_if});
    if (e_if) begin
      chk("if_pc", io_if_pc, m_buf_pc);
      chk("if_inst", io_if_inst, m_buf_inst);
    end
    acc = e_req && rq_rdy;
    if (rst) begin
      m_pc = RST_PC; m_out = 1'b0; m_squash = 1'b0; m_buf = 1'b0;
    end else begin
      o_out = m_out;
      o_buf = m_buf;
      if (rsp_v && o_out) begin
        m_out = 1'b0;
        if (!m_squash && !rd) begin
          m_buf = 1'b1; m_buf_pc = m_pc; m_buf_inst = rsp_d; m_pc = m_pc + 32'd4;
        end
        m_squash = 1'b0;
      end
      if (o_buf && (rd || ifr)) m_buf = 1'b0;
      if (acc) begin m_out = 1'b1; m_squash = rd; end
      if (o_out && !rsp_v && rd) m_squash = 1'b1;
      if (rd) m_pc = rpc & ~32'h3;
    end
  endtask

  initial begin
    logic acc, rd, rr, rv, ifr, rst;
    logic [31:0] rpc, rdat;
    m_pc = RST_PC; m_out = 0; m_squash = 0; m_buf = 0; m_buf_pc = 0; m_buf_inst = 0;
    mem_pend = 0;

    step(0, 0, 0, 0, 0, 0, 1, acc);
    step(0, 0, 1, 0, 0, 1, 1, acc);

    // Straight-line fetch, one instruction per three cycles
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 0, 1, 0, acc);
      chk("t1_addr", io_imem_req_addr, RST_PC + 32'(4 * i));
      step(0, 0, 1, 1, $urandom, 1, 0, acc);
      step(0, 0, 1, 0, 0, 1, 0, acc);
      chk("t1_if_pc", io_if_pc, RST_PC + 32'(4 * i));
    end

    // Decode stalls in HOLD
    step(0, 0, 1, 0, 0, 0, 0, acc);
    step(0, 0, 1, 1, 32'hDEAD_BEEF, 0, 0, acc);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 0, 0, 0, acc);
      chk("t2_if_pc", io_if_pc, 32'h8000_0010);
      chk("t2_if_inst", io_if_inst, 32'hDEAD_BEEF);
      chk("t2_no_req", {31'b0, io_imem_req_valid}, 32'h0);
    end
    step(0, 0, 0, 0, 0, 1, 0, acc);

    // Redirect while waiting for a response
    step(0, 0, 1, 0, 0, 0, 0, acc);
    step(1, 32'h0000_1003, 0, 0, 0, 0, 0, acc);
    step(0, 0, 0, 1, 32'h1111_1111, 1, 0, acc);
    chk("t3_if_valid", {31'b0, io_if_valid}, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, acc);
    chk("t3_addr", io_imem_req_addr, 32'h0000_1000);

    // Redirect and if_ready together in HOLD
    step(0, 0, 1, 0, 0, 0, 0, acc);
    step(0, 0, 0, 1, 32'h2222_2222, 0, 0, acc);
    step(1, 32'h0000_2000, 0, 0, 0, 1, 0, acc);
    chk("t4_if_valid", {31'b0, io_if_valid}, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, acc);
    chk("t4_addr", io_imem_req_addr, 32'h0000_2000);

    // Redirect in the same cycle the request is accepted
    step(1, 32'h0000_3000, 1, 0, 0, 0, 0, acc);
    step(0, 0, 1, 1, 32'h3333_3333, 1, 0, acc);
    step(0, 0, 1, 0, 0, 1, 0, acc);
    chk("t5_addr", io_imem_req_addr, 32'h0000_3000);
    step(0, 0, 1, 1, 32'h4444_4444, 0, 0, acc);
    step(0, 0, 0, 0, 0, 1, 0, acc);
    chk("t5_if_pc", io_if_pc, 32'h0000_3000);

    // PC wrap, then reset while waiting
    step(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, acc);
    step(0, 0, 1, 0, 0, 0, 0, acc);
    step(0, 0, 1, 1, 32'h5555_5555, 0, 0, acc);
    step(0, 0, 1, 0, 0, 1, 0, acc);
    chk("t6_if_pc", io_if_pc, 32'hFFFF_FFFC);
    step(0, 0, 1, 0, 0, 1, 0, acc);
    chk("t6_wrap_addr", io_imem_req_addr, 32'h0000_0000);
    step(0, 0, 0, 0, 0, 0, 1, acc);
    step(0, 0, 0, 0, 0, 0, 0, acc);
    chk("t6_reset_addr", io_imem_req_addr, RST_PC);

    // Randomized traffic with an in-order, single-outstanding memory
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(299) == 0);
      rd   = ($urandom_range(7) == 0);
      rpc  = $urandom;
      rr   = 1'($urandom_range(1));
      ifr  = 1'($urandom_range(1));
      rv   = mem_pend ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0);
      rdat = $urandom;
      step(rd, rpc, rr, rv, rdat, ifr, rst, acc);
      if (rst) mem_pend = 0;
      else begin
        if (rv) mem_pend = 0;
        if (acc) mem_pend = 1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
